// File: rtl/seg_pkg.sv
// Shared seven-segment constants, display-mode type and hex-to-segment decode.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic       AN_OFF  = 1'b1;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   typedef enum logic [1:0] {
      DISP_GUARD,
      DISP_BLANK,
      DISP_BLINK,
      DISP_LIT
   } disp_mode_e;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      s = SEG_0;
      case (nib)
         4'h0: s = SEG_0;
         4'h1: s = SEG_1;
         4'h2: s = SEG_2;
         4'h3: s = SEG_3;
         4'h4: s = SEG_4;
         4'h5: s = SEG_5;
         4'h6: s = SEG_6;
         4'h7: s = SEG_7;
         4'h8: s = SEG_8;
         4'h9: s = SEG_9;
         4'hA: s = SEG_A;
         4'hB: s = SEG_B;
         4'hC: s = SEG_C;
         4'hD: s = SEG_D;
         4'hE: s = SEG_E;
         4'hF: s = SEG_F;
         default: s = SEG_0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder, shared by display paths.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg_n
);

   assign seg_n = hex_to_seg(nib);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit common-anode scan driver with frame snapshot, guard interval,
// blanking and blinking. Define SEG_LZ_BLANK_EN to suppress leading zeros at snapshot time.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int N_DIGITS     = 8,
   parameter int DIV          = 100000,
   parameter int GUARD        = 16,
   parameter int BLINK_FRAMES = 64
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*N_DIGITS-1:0]   digits,
   input  logic [N_DIGITS-1:0]     dp,
   input  logic [N_DIGITS-1:0]     blank_mask,
   input  logic [N_DIGITS-1:0]     blink_mask,
   output logic [N_DIGITS-1:0]     AN,
   output logic [7:0]              SEG,
   output logic                    frame_tick
);

   localparam int IDXW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNTW = $clog2(DIV);
   localparam int BFW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DIV - 1);
   localparam logic [CNTW-1:0] CNT_GUARD = CNTW'(GUARD);
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N_DIGITS - 1);
   localparam logic [BFW-1:0]  BF_LAST   = BFW'(BLINK_FRAMES - 1);

   logic [CNTW-1:0]         cnt_q, cnt_d;
   logic [IDXW-1:0]         idx_q, idx_d;
   logic [4*N_DIGITS-1:0]   snap_digits_q, snap_digits_d;
   logic [N_DIGITS-1:0]     snap_dp_q, snap_dp_d;
   logic [N_DIGITS-1:0]     snap_blank_q, snap_blank_d;
   logic [N_DIGITS-1:0]     snap_blink_q, snap_blink_d;
   logic [BFW-1:0]          bf_q, bf_d;
   logic                    phase_q, phase_d;
   logic [N_DIGITS-1:0]     an_q, an_d;
   logic [7:0]              seg_q, seg_d;
   logic                    frame_tick_q, frame_tick_d;

   logic                    frame_wrap;
   logic [N_DIGITS-1:0]     lz_mask;
   logic [3:0]              nib;
   logic [6:0]              dec_seg;
   disp_mode_e              mode;

`ifdef SEG_LZ_BLANK_EN
   logic leading;

   // Walk down from the leftmost digit; digit 0 always stays visible.
   always_comb begin
      lz_mask = '0;
      leading = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         if (leading && (digits[4*i +: 4] == 4'h0) && !dp[i]) begin
            lz_mask[i] = 1'b1;
         end else begin
            leading = 1'b0;
         end
      end
   end
`else
   assign lz_mask = '0;
`endif

   always_comb begin
      frame_wrap    = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
      cnt_d         = cnt_q + 1'b1;
      idx_d         = idx_q;
      snap_digits_d = snap_digits_q;
      snap_dp_d     = snap_dp_q;
      snap_blank_d  = snap_blank_q;
      snap_blink_d  = snap_blink_q;
      bf_d          = bf_q;
      phase_d       = phase_q;
      frame_tick_d  = frame_wrap;

      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      if (frame_wrap) begin
         snap_digits_d = digits;
         snap_dp_d     = dp;
         snap_blank_d  = blank_mask | lz_mask;
         snap_blink_d  = blink_mask;
         if (bf_q == BF_LAST) begin
            bf_d    = '0;
            phase_d = ~phase_q;
         end else begin
            bf_d = bf_q + 1'b1;
         end
      end
   end

   assign nib = snap_digits_q[{idx_q, 2'b00} +: 4];

   seg_hex_decode u_hex_decode (
      .nib   (nib),
      .seg_n (dec_seg)
   );

   // Output register input: decided purely from current registered state.
   always_comb begin
      an_d  = {N_DIGITS{AN_OFF}};
      seg_d = SEG_OFF;
      if (cnt_q < CNT_GUARD) begin
         mode = DISP_GUARD;
      end else if (snap_blank_q[idx_q]) begin
         mode = DISP_BLANK;
      end else if (phase_q && snap_blink_q[idx_q]) begin
         mode = DISP_BLINK;
      end else begin
         mode = DISP_LIT;
      end
      if (mode == DISP_LIT) begin
         an_d[idx_q] = ~AN_OFF;
         seg_d       = {~snap_dp_q[idx_q], dec_seg};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         snap_digits_q <= '0;
         snap_dp_q     <= '0;
         snap_blank_q  <= '0;
         snap_blink_q  <= '0;
         bf_q          <= '0;
         phase_q       <= 1'b0;
         an_q          <= {N_DIGITS{AN_OFF}};
         seg_q         <= SEG_OFF;
         frame_tick_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         snap_digits_q <= snap_digits_d;
         snap_dp_q     <= snap_dp_d;
         snap_blank_q  <= snap_blank_d;
         snap_blink_q  <= snap_blink_d;
         bf_q          <= bf_d;
         phase_q       <= phase_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign AN         = an_q;
   assign SEG        = seg_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: per-cycle comparison against a time-indexed reference model.
module tb_seg_scan_driver;

   localparam int N     = 8;
   localparam int DIV   = 4;
   localparam int GUARD = 1;
   localparam int BF    = 2;
   localparam int FRAME = N * DIV;
`ifdef SEG_LZ_BLANK_EN
   localparam bit LZ_EN = 1'b1;
`else
   localparam bit LZ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] digits = '0;
   logic [7:0]  dp = '0;
   logic [7:0]  blank_mask = '0;
   logic [7:0]  blink_mask = '0;
   logic [7:0]  AN;
   logic [7:0]  SEG;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;
   int s = 0;

   // Model: snapshot in use by the frame being displayed, and the one captured for the next frame.
   logic [31:0] c_dig, p_dig;
   logic [7:0]  c_dp, p_dp, c_bl, p_bl, c_bk, p_bk;

   logic [7:0] dec8 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   seg_scan_driver #(
      .N_DIGITS     (N),
      .DIV          (DIV),
      .GUARD        (GUARD),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .digits     (digits),
      .dp         (dp),
      .blank_mask (blank_mask),
      .blink_mask (blink_mask),
      .AN         (AN),
      .SEG        (SEG),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lz(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
      logic [7:0] m;
      m = '0;
      for (int i = N - 1; i >= 1; i--) begin
         if (d[4*i +: 4] != 4'h0 || p[i]) break;
         m[i] = 1'b1;
      end
      return b | (LZ_EN ? m : 8'h00);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h state=%0d", tag, got, exp, s);
      end
   endtask

   task automatic model_clear();
      s = 0;
      c_dig = '0; c_dp = '0; c_bl = '0; c_bk = '0;
      p_dig = '0; p_dp = '0; p_bl = '0; p_bk = '0;
   endtask

   task automatic step();
      int p, pos, slot, f;
      logic [7:0] ea, es, d8;
      @(posedge clk);
      #1;
      s++;
      p = s - 1;
      if (p > 0 && p % FRAME == 0) begin
         c_dig = p_dig; c_dp = p_dp; c_bl = p_bl; c_bk = p_bk;
      end
      pos  = p % DIV;
      slot = (p / DIV) % N;
      f    = p / FRAME;
      ea = 8'hFF;
      es = 8'hFF;
      if (pos >= GUARD && !c_bl[slot] && !(((f / BF) % 2 == 1) && c_bk[slot])) begin
         ea[slot] = 1'b0;
         d8 = dec8[c_dig[4*slot +: 4]];
         es = {~c_dp[slot], d8[6:0]};
      end
      check("AN", AN, ea);
      check("SEG", SEG, es);
      check("frame_tick", frame_tick, (p % FRAME == FRAME - 1));
      if (p % FRAME == FRAME - 1) begin
         p_dig = digits; p_dp = dp; p_bl = lz(digits, dp, blank_mask); p_bk = blink_mask;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      model_clear();
      #12;
      check("rst_AN", AN, 8'hFF);
      check("rst_SEG", SEG, 8'hFF);
      check("rst_tick", frame_tick, 1'b0);
      reset = 1'b0;
      model_clear();

      // Basic scan: first frame zeros, then the real digits
      digits = 32'h76543210;
      run(3 * FRAME);

      // Mid-frame change of digit 3 to 8
      run(10);
      digits = 32'h76548210;
      run(2 * FRAME);

      // Digit 0 blanked and blink-masked
      blank_mask = 8'h01;
      blink_mask = 8'h01;
      run(4 * FRAME);

      // Digit 1 blinks showing 4
      blank_mask = 8'h00;
      blink_mask = 8'h02;
      digits = 32'h76548240;
      run(8 * FRAME);

      // Leading-zero patterns
      blink_mask = 8'h00;
      digits = 32'h00000050;
      run(2 * FRAME);
      digits = 32'h00000000;
      run(2 * FRAME);
      digits = 32'h00300000;
      dp = 8'h80;
      run(2 * FRAME);
      dp = 8'h00;

      // Randomized inputs changing at arbitrary cycles
      for (int i = 0; i < 24 * FRAME; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 4))
               0: digits = $urandom;
               1: dp = 8'($urandom);
               2: blank_mask = 8'($urandom) & 8'($urandom);
               3: blink_mask = 8'($urandom);
               default: digits = {$urandom_range(0, 1) == 0 ? 16'h0000 : 16'($urandom), 16'($urandom)};
            endcase
         end
         step();
      end

      // Reset asserted during slot 5
      for (int i = 0; i < 2 * FRAME && ((s / DIV) % N) != 5; i++) step();
      check("reached_slot5", (s / DIV) % N, 5);
      reset = 1'b1;
      #1;
      check("async_rst_AN", AN, 8'hFF);
      check("async_rst_SEG", SEG, 8'hFF);
      check("async_rst_tick", frame_tick, 1'b0);
      @(posedge clk);
      #1;
      check("held_rst_AN", AN, 8'hFF);
      check("held_rst_SEG", SEG, 8'hFF);
      #2;
      reset = 1'b0;
      model_clear();
      digits = 32'h89ABCDEF;
      dp = 8'h00;
      blank_mask = 8'h00;
      blink_mask = 8'h00;
      run(3 * FRAME);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage of the vending-machine top level.
- Consumes the per-digit values the controller produces (balance, price, change, state code) and time-multiplexes them onto the board's 8-digit common-anode seven-segment display through AN/SEG.
- Provides a frame snapshot so digits never tear, an anti-ghosting guard interval, per-digit blanking and per-digit blinking (e.g. "insert coin" or "no change" prompts).

Parameters:
- N_DIGITS, 8, number of multiplexed digits; index width is clog2(N_DIGITS).
- DIV, 100000, clk cycles per digit slot; must be >= GUARD+2.
- GUARD, 16, cycles at the start of each slot with all anodes off (anti-ghosting).
- BLINK_FRAMES, 64, full frames per blink half-period.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- digits  in  4*N_DIGITS  hex nibble per digit; digit i = digits[4i+3:4i]; digit 0 is rightmost
- dp  in  N_DIGITS  decimal point request per digit (1 = lit)
- blank_mask  in  N_DIGITS  1 = digit forced dark
- blink_mask  in  N_DIGITS  1 = digit dark during the blink-off phase
- AN  out  N_DIGITS  anode enables, active-low
- SEG  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async, active-high), all values immediate:
  - AN=all 1s, SEG=8'hFF, frame_tick=0.
  - Prescaler cnt=0, slot index idx=0, snapshot registers=0.
  - Blink frame counter=0, blink phase=0 (visible).
- Reset mid-scan: same values immediately; scanning restarts from idx=0, cnt=0 after deassertion.
- Prescaler: cnt counts 0..DIV-1. At cnt==DIV-1, cnt<=0 and idx<=idx+1. idx wraps from N_DIGITS-1 to 0.
- Frame wrap: the cycle where cnt==DIV-1 and idx==N_DIGITS-1. On that cycle:
  - digits, dp, blank_mask and blink_mask are copied into the snapshot registers.
  - frame_tick is registered high for exactly the next cycle.
  - The blink frame counter advances. When it reaches BLINK_FRAMES-1 it returns to 0 and blink phase toggles.
- The first frame after reset shows snapshot contents of 0, i.e. "0" on every unblanked digit.
- All display decisions use only the snapshot registers; input changes mid-frame have no visible effect until the next frame.
- Output decision, evaluated from registered state:
  - If cnt < GUARD: AN=all 1s, SEG=8'hFF.
  - Else if snapshot blank_mask[idx]=1: AN=all 1s, SEG=8'hFF.
  - Else if blink phase=1 and snapshot blink_mask[idx]=1: AN=all 1s, SEG=8'hFF.
  - Otherwise: AN=~(1<<idx), SEG[6:0]=decode(snapshot nibble idx), SEG[7]=~snapshot dp[idx].
- Priority: blank > blink > normal.
- Latency: AN and SEG are registered. The value at cycle t+1 reflects cnt/idx/snapshot/phase at cycle t.
- Decode, active-low g..a:
  - 0=C0 (with dp off), 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - A=88, B=83, C=C6, D=A1, E=86, F=8E.
- At most one AN bit is low in any cycle. Glitch-free: AN and SEG change only on clock edges.

Optional Feature:
- Macro SEG_LZ_BLANK_EN.
- When defined: leading-zero suppression is applied at snapshot time. Starting at digit N_DIGITS-1 and moving downward, each digit whose nibble is 0 and whose dp bit is 0 is ORed into the snapshot blank_mask. Suppression stops at the first nonzero nibble or set dp bit. Digit 0 is never suppressed.
- When undefined: the snapshot blank_mask equals the input blank_mask exactly, and zeros display normally.

Decomposition:
- Shared package seg_pkg:
  - SEG_OFF=8'hFF and AN_OFF constants.
  - Segment-code constants for 0..F.
  - Nibble-to-segment decode function.
- Sub-module seg_hex_decode: pure combinational, 4-bit in, 7-bit active-low out. Reused by other display paths in the design.
- Prescaler, index, snapshot, blink logic and output register stay in seg_scan_driver.

Test Plan (DIV=4, GUARD=1, BLINK_FRAMES=2, N_DIGITS=8):
- Reset then release, digits=32'h76543210 → AN/SEG stay FF for the first frame except "0" patterns (C0) on each slot. From the second frame, the slot with AN=FE shows SEG=C0, AN=FD shows F9, AN=7F shows F8. Each AN is low for exactly 3 of every 4 cycles. frame_tick pulses every 32 cycles.
- Change digits mid-frame (set digit 3 to 8) → the digit-3 slot is unchanged until after the next frame_tick, then shows SEG=80.
- blank_mask=8'h01, blink_mask=8'h01 → digit 0 is never lit, and no AN bit 0 is low in any cycle.
- blink_mask=8'h02, digit1=4 → digit 1 shows 99 for 2 frames and is dark for 2 frames, repeating. Other digits are unaffected.
- Assert reset during slot 5 → AN=FF and SEG=FF in the same cycle (async). After release, slot 0 is the first lit slot at cycle GUARD+1.
- With SEG_LZ_BLANK_EN: digits=32'h00000050 → only digits 1 and 0 are lit (92, C0). digits=0 → only digit 0 is lit (C0). Without the macro, all 8 digits are lit.
